// File: rtl/c_sub_arb.sv
// Round-robin arbiter sharing one 15-bit subtractor among NUM_REQ requesters.
// Optional build macro C_SUB_ARB_SAT_EN selects an unsigned saturating subtract.
module c_sub_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ*15-1:0] req_a,
    input  logic [NUM_REQ*15-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [ID_W-1:0]       rsp_id,
    output logic [14:0]           rsp_s,
    output logic                  busy,
    output logic [15:0]           op_cnt
);
    localparam int DW = 15;

    // Handshakes: a request transfers on req_vld[i] & req_rdy[i]; a result
    // transfers on rsp_vld & rsp_rdy, with rsp_* held stable until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_s_q, rsp_s_d;
    logic [15:0]     op_cnt_q, op_cnt_d;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [DW-1:0]      sub_res;

    // First valid requester at or after ptr, scanning upward with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_vld[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && (int'(gnt_idx) == i)) begin
                gnt_oh[i] = 1'b1;
            end
        end
    end

    // Gated by rst_n so the grant is also zero while reset is held.
    assign req_rdy = (state_q == IDLE && rst_n) ? gnt_oh : '0;

    always_comb begin
`ifdef C_SUB_ARB_SAT_EN
        sub_res = (a_q < b_q) ? '0 : (a_q - b_q);
`else
        sub_res = a_q - b_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_s_d   = rsp_s_q;
        op_cnt_d  = op_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    a_d     = req_a[int'(gnt_idx)*DW +: DW];
                    b_d     = req_b[int'(gnt_idx)*DW +: DW];
                    id_d    = gnt_idx;
                    ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_s_d   = sub_res;
                rsp_id_d  = id_q;
                rsp_vld_d = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    op_cnt_d  = op_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_s_q   <= '0;
            op_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_s_q   <= rsp_s_d;
            op_cnt_q  <= op_cnt_d;
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_id  = rsp_id_q;
    assign rsp_s   = rsp_s_q;
    assign busy    = (state_q != IDLE);
    assign op_cnt  = op_cnt_q;

endmodule
